// File: rtl/micro_seq_pkg.sv
// Shared definitions for the shift-add multiplier micro-sequencer and its control decoder.
// Latency: n/a (types, constants and a field-extract helper only).
// Backpressure: n/a.
package micro_pkg;

    // Sequencer phases: FETCH/DECODE/EXEC are the T0/T1/T2 strobes.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        DONE
    } state_t;

    localparam int INSTR_W  = 8;
    localparam int OPC_W    = 4;
    localparam int OPC_LSB  = 4;

    // Control bits carried alongside the opcode in every micro-instruction.
    localparam int END_BIT  = 3;
    localparam int LOOP_BIT = 2;
    localparam int MARK_BIT = 1;
    localparam int RSVD_BIT = 0;

    // Opcode space shared with the control decoder.
    localparam logic [OPC_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OPC_W-1:0] OP_CLR_ACC  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LD_MCAND = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD_COND = 4'h3;
    localparam logic [OPC_W-1:0] OP_SHR_ACC  = 4'h4;
    localparam logic [OPC_W-1:0] OP_SHR_MPLR = 4'h5;
    localparam logic [OPC_W-1:0] OP_LD_MPLR  = 4'h6;
    localparam logic [OPC_W-1:0] OP_ST_LO    = 4'h7;
    localparam logic [OPC_W-1:0] OP_STEP     = 4'h8;
    localparam logic [OPC_W-1:0] OP_ST_HI    = 4'h9;
    localparam logic [OPC_W-1:0] OP_SUB_COND = 4'hA;
    localparam logic [OPC_W-1:0] OP_SHL_ACC  = 4'hB;
    localparam logic [OPC_W-1:0] OP_CLR_CY   = 4'hC;
    localparam logic [OPC_W-1:0] OP_SET_CY   = 4'hD;
    localparam logic [OPC_W-1:0] OP_RSVD_E   = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT     = 4'hF;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Bundle between the micro-sequencer, its program store and the control decoder.
// Latency: n/a (wires only).
// Backpressure: none; prog_data is a combinational read of prog_addr.
interface micro_seq_if #(
    parameter int PC_W = 4
);
    import micro_pkg::*;

    logic                 start;
    logic                 mult_bit;
    logic [INSTR_W-1:0]   prog_data;
    logic [PC_W-1:0]      prog_addr;
    logic [OPC_W-1:0]     opcode;
    logic                 flag;
    logic                 T0;
    logic                 T1;
    logic                 T2;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, mult_bit, prog_data,
        output prog_addr, opcode, flag, T0, T1, T2, busy, done
    );

    modport slave (
        output start, mult_bit, prog_data,
        input  prog_addr, opcode, flag, T0, T1, T2, busy, done
    );

endinterface

// File: rtl/micro_seq_loop_ctr.sv
// Hardware loop state: iteration counter plus the marked loop-head address.
// Latency: jump/target combinational from inputs and state; state updates on the next edge.
// Backpressure: none; update strobes are single-cycle pulses from the sequencer.
module micro_loop_ctr #(
    parameter int PC_W   = 4,
    parameter int LOOP_N = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            mark,
    input  logic            loop,
    input  logic [PC_W-1:0] pc,
    output logic            jump,
    output logic [PC_W-1:0] target
);

    localparam int CNT_W = (LOOP_N < 2) ? 1 : $clog2(LOOP_N + 1);

    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  mark_pc;

    // A MARK in the same word as LOOP makes that word its own loop head.
    assign target = mark ? pc : mark_pc;

    // Last pass (cnt==1) and an exhausted counter (cnt==0) both fall through.
    assign jump = loop && (cnt > CNT_W'(1));

    // Counter reloads on start and counts down to zero on each LOOP; never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            mark_pc <= '0;
        end else begin
            if (mark) begin
                mark_pc <= pc;
            end
            if (load) begin
                cnt <= CNT_W'(LOOP_N);
            end else if (loop && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/micro_seq.sv
// Three-phase (fetch/decode/execute) micro-sequencer with one hardware loop; MICRO_SEQ_STEP_EN adds single-step.
// Latency: start -> T0 next cycle; 3 cycles per instruction; done 3k+1 cycles after start for k instructions.
// Backpressure: start ignored unless idle; with MICRO_SEQ_STEP_EN, fetch stalls until step is high.
module micro_seq
    import micro_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int LOOP_N = 8
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MICRO_SEQ_STEP_EN
    input  logic        step,
`endif
    micro_seq_if.master bus
);

    state_t             state_q;
    state_t             state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] ir_q;
    logic               flag_q;

    logic               ir_ld;
    logic               flag_ld;
    logic               ctr_load;
    logic               ctr_mark;
    logic               ctr_loop;
    logic               ctr_jump;
    logic [PC_W-1:0]    ctr_target;
    logic               fetch_go;
    logic               unused_rsvd;

`ifdef MICRO_SEQ_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Reserved instruction bit carries no meaning yet.
    assign unused_rsvd = ir_q[RSVD_BIT];

    micro_loop_ctr #(
        .PC_W   (PC_W),
        .LOOP_N (LOOP_N)
    ) u_loop_ctr (
        .clk    (clk),
        .reset  (reset),
        .load   (ctr_load),
        .mark   (ctr_mark),
        .loop   (ctr_loop),
        .pc     (pc_q),
        .jump   (ctr_jump),
        .target (ctr_target)
    );

    // State, program counter, instruction and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_ld) begin
                ir_q <= bus.prog_data;
            end
            if (flag_ld) begin
                flag_q <= bus.mult_bit;
            end
        end
    end

    // Phase sequencing and end-of-execute program counter update.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_ld    = 1'b0;
        flag_ld  = 1'b0;
        ctr_load = 1'b0;
        ctr_mark = 1'b0;
        ctr_loop = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (bus.start) begin
                    state_d  = FETCH;
                    ctr_load = 1'b1;
                end
            end
            FETCH: begin
                if (fetch_go) begin
                    ir_ld   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                flag_ld = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                ctr_mark = ir_q[MARK_BIT];
                if (ir_q[END_BIT]) begin
                    // END wins over LOOP and leaves pc where it is.
                    state_d = DONE;
                end else begin
                    state_d  = FETCH;
                    ctr_loop = ir_q[LOOP_BIT];
                    pc_d     = ctr_jump ? ctr_target : pc_q + PC_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                pc_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.prog_addr = pc_q;
    assign bus.opcode    = instr_opcode(ir_q);
    assign bus.flag      = flag_q;
    assign bus.T0        = (state_q == FETCH);
    assign bus.T1        = (state_q == DECODE);
    assign bus.T2        = (state_q == EXEC);
    assign bus.busy      = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: stimulus pushes expected T2/done/fetch events, a monitor pops and compares.
// Latency: checks T2 and done cycle positions relative to the start cycle.
// Backpressure: exercises start-while-busy and, with MICRO_SEQ_STEP_EN, the fetch stall.
`timescale 1ns/1ps
module tb_micro_seq;
    import micro_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic       fl;
        int         cyc;
    } exp_t2_t;

    typedef struct {
        int addr;
        int cyc;
    } exp_fa_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon2_en = 1'b0;

    exp_t2_t q_t2[$];
    int      q_done[$];
    exp_fa_t q_fa[$];

    logic [7:0] rom [16];

`ifdef MICRO_SEQ_STEP_EN
    logic step = 1'b1;
`endif

    micro_seq_if #(.PC_W(4)) ifc();
    micro_seq_if #(.PC_W(2)) ifc2();

    assign ifc.prog_data  = rom[ifc.prog_addr];
    assign ifc2.prog_data = 8'h10;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    micro_seq #(.PC_W(4), .LOOP_N(8)) u_dut (
        .clk   (clk),
        .reset (reset),
`ifdef MICRO_SEQ_STEP_EN
        .step  (step),
`endif
        .bus   (ifc.master)
    );

    micro_seq #(.PC_W(2), .LOOP_N(8)) u_dut2 (
        .clk   (clk),
        .reset (reset2),
`ifdef MICRO_SEQ_STEP_EN
        .step  (step),
`endif
        .bus   (ifc2.master)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_t2(input logic [3:0] op, input logic fl, input int c);
        exp_t2_t e;
        e.op = op;
        e.fl = fl;
        e.cyc = c;
        q_t2.push_back(e);
    endtask

    task automatic do_start(output int sc);
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    // Waits until the monitor has consumed the expected done; optionally drives mult_bit per DECODE slot.
    task automatic wait_done(input int limit, input string name, input int sc, input bit flag_mode,
                             input logic [2:0] mpat);
        int n;
        int rel;
        int idx;
        n = 0;
        while (q_done.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (flag_mode) begin
                rel = cyc - sc;
                idx = rel / 3;
                if (idx < 3) ifc.mult_bit = (rel % 3 == 2) ? mpat[idx] : ~mpat[idx];
                else ifc.mult_bit = 1'b0;
            end
        end
        if (q_done.size() != 0) begin
            chk(1'b0, name, n, limit);
            q_done.delete();
        end
        ifc.mult_bit = 1'b0;
    endtask

    // Monitor: compares every T1/T2/done of the main DUT and every fetch of the PC_W=2 DUT.
    always @(negedge clk) begin
        exp_t2_t e;
        exp_fa_t f;
        int      dc;
        if (ifc.T1) begin
            if (q_t2.size() == 0) chk(1'b0, "t1_unexpected", ifc.opcode, -1);
            else chk(ifc.opcode == q_t2[0].op, "t1_opcode", ifc.opcode, q_t2[0].op);
        end
        if (ifc.T2) begin
            if (q_t2.size() == 0) begin
                chk(1'b0, "t2_unexpected", ifc.opcode, -1);
            end else begin
                e = q_t2.pop_front();
                chk(ifc.opcode == e.op, "t2_opcode", ifc.opcode, e.op);
                chk(ifc.flag == e.fl, "t2_flag", ifc.flag, e.fl);
                if (e.cyc >= 0) chk(cyc == e.cyc, "t2_cycle", cyc, e.cyc);
            end
        end
        if (ifc.done) begin
            if (q_done.size() == 0) begin
                chk(1'b0, "done_unexpected", cyc, -1);
            end else begin
                dc = q_done.pop_front();
                if (dc >= 0) chk(cyc == dc, "done_cycle", cyc, dc);
                else chk(q_t2.size() == 0, "done_after_all_t2", q_t2.size(), 0);
            end
        end
        if (mon2_en && ifc2.T0 && q_fa.size() != 0) begin
            f = q_fa.pop_front();
            chk(int'(ifc2.prog_addr) == f.addr, "pcw2_fetch_addr", ifc2.prog_addr, f.addr);
            chk(cyc == f.cyc, "pcw2_fetch_cycle", cyc, f.cyc);
        end
    end

    initial begin
        int      sc;
        int      n;
        exp_fa_t f;
        ifc.start     = 1'b0;
        ifc.mult_bit  = 1'b0;
        ifc2.start    = 1'b0;
        ifc2.mult_bit = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk(ifc.opcode == 4'h0, "rst_opcode", ifc.opcode, 0);
        chk(ifc.prog_addr == 4'h0, "rst_pc", ifc.prog_addr, 0);
        chk(ifc.flag == 1'b0, "rst_flag", ifc.flag, 0);
        chk({ifc.T0, ifc.T1, ifc.T2} == 3'b000, "rst_phase", {ifc.T0, ifc.T1, ifc.T2}, 0);
        chk(ifc.busy == 1'b0, "rst_busy", ifc.busy, 0);
        chk(ifc.done == 1'b0, "rst_done", ifc.done, 0);

        // Straight-line program: opcodes 0,1,2 then done 10 cycles after start.
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h28;
        do_start(sc);
        push_t2(4'h0, 1'b0, sc + 3);
        push_t2(4'h1, 1'b0, sc + 6);
        push_t2(4'h2, 1'b0, sc + 9);
        q_done.push_back(sc + 10);
        wait_done(40, "prog1_timeout", sc, 1'b0, 3'b000);
        chk(ifc.prog_addr == 4'h0, "prog1_pc_after_done", ifc.prog_addr, 0);
        chk(ifc.busy == 1'b0, "prog1_busy_after_done", ifc.busy, 0);

        // Hardware loop: 0, then (8,3) x8, then F; done at 3*18+1.
        rom[0] = 8'h00; rom[1] = 8'h82; rom[2] = 8'h34; rom[3] = 8'hF8;
        do_start(sc);
        push_t2(4'h0, 1'b0, sc + 3);
        for (int i = 0; i < 8; i++) begin
            push_t2(4'h8, 1'b0, sc + 6 + 6 * i);
            push_t2(4'h3, 1'b0, sc + 9 + 6 * i);
        end
        push_t2(4'hF, 1'b0, sc + 54);
        q_done.push_back(sc + 55);
        wait_done(100, "loop_timeout", sc, 1'b0, 3'b000);
        chk(ifc.prog_addr == 4'h0, "loop_pc_after_done", ifc.prog_addr, 0);

        // Flag capture: mult_bit 1,0,1 in the three DECODE slots, inverted elsewhere.
        rom[0] = 8'h50; rom[1] = 8'h60; rom[2] = 8'h78;
        do_start(sc);
        push_t2(4'h5, 1'b1, sc + 3);
        push_t2(4'h6, 1'b0, sc + 6);
        push_t2(4'h7, 1'b1, sc + 9);
        q_done.push_back(sc + 10);
        wait_done(40, "flag_timeout", sc, 1'b1, 3'b101);

        // Reset during EXEC of the second instruction, then a clean rerun from address 0.
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h28;
        do_start(sc);
        push_t2(4'h0, 1'b0, sc + 3);
        push_t2(4'h1, 1'b0, sc + 6);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(ifc.opcode == 4'h0, "midrst_opcode", ifc.opcode, 0);
        chk(ifc.T2 == 1'b0, "midrst_t2", ifc.T2, 0);
        chk(ifc.busy == 1'b0, "midrst_busy", ifc.busy, 0);
        chk(ifc.prog_addr == 4'h0, "midrst_pc", ifc.prog_addr, 0);
        chk(q_t2.size() == 0, "midrst_t2_drained", q_t2.size(), 0);
        reset = 1'b0;
        do_start(sc);
        push_t2(4'h0, 1'b0, sc + 3);
        push_t2(4'h1, 1'b0, sc + 6);
        push_t2(4'h2, 1'b0, sc + 9);
        q_done.push_back(sc + 10);
        wait_done(40, "rerun_timeout", sc, 1'b0, 3'b000);

        // PC_W=2 program with no END: fetch addresses wrap 0,1,2,3,0,1; start while busy ignored.
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        ifc2.start = 1'b1;
        sc = cyc;
        mon2_en = 1'b1;
        @(posedge clk);
        #1;
        ifc2.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            f.addr = i % 4;
            f.cyc  = sc + 1 + 3 * i;
            q_fa.push_back(f);
        end
        n = 0;
        while (q_fa.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            ifc2.start = ((cyc - sc) == 4) || ((cyc - sc) == 8);
        end
        ifc2.start = 1'b0;
        mon2_en = 1'b0;
        chk(q_fa.size() == 0, "pcw2_fetch_count", q_fa.size(), 0);
        chk(ifc2.busy == 1'b1, "pcw2_still_busy", ifc2.busy, 1);
        reset2 = 1'b1;

`ifdef MICRO_SEQ_STEP_EN
        // Single-step: FETCH holds with step low, one pulse executes one instruction.
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h28;
        step = 1'b0;
        do_start(sc);
        for (int i = 0; i < 5; i++) begin
            chk(ifc.T0 == 1'b1, "step_t0_held", ifc.T0, 1);
            chk(ifc.T2 == 1'b0, "step_no_t2", ifc.T2, 0);
            @(posedge clk);
            #1;
        end
        push_t2(4'h0, 1'b0, -1);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(q_t2.size() == 0, "step_one_t2", q_t2.size(), 0);
        chk(ifc.T0 == 1'b1, "step_t0_held_again", ifc.T0, 1);
        push_t2(4'h1, 1'b0, -1);
        push_t2(4'h2, 1'b0, -1);
        q_done.push_back(-1);
        step = 1'b1;
        wait_done(40, "step_timeout", sc, 1'b0, 3'b000);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk(q_t2.size() == 0, "t2_queue_empty", q_t2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/micro_seq.md
# micro_seq

Micro-sequencer for the shift-add multiplier. Fetches 8-bit micro-instructions from an external combinational program store and drives the opcode, flag and T2 execute strobe that the control decoder turns into register, shifter and ALU enables. Runs a three-phase cycle (T0 fetch, T1 decode, T2 execute) per instruction. Supports one hardware loop, so the per-bit multiply step repeats once per multiplier bit.

## Interface
- PC_W, 4: program counter width; program depth is 2^PC_W words.
- LOOP_N, 8: loop iteration count loaded on start (multiplier width); 1..2^PC_W-1 not required, any value ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin program at address 0; sampled only in IDLE.
- mult_bit  in  1  current multiplier LSB from datapath.
- prog_data  in  8  instruction word at prog_addr: [7:4] opcode, [3] END, [2] LOOP, [1] MARK, [0] reserved (ignored).
- prog_addr  out  PC_W  current program counter.
- opcode  out  4  decoded instruction opcode to control decoder.
- flag  out  1  registered mult_bit for conditional accumulate.
- T0, T1, T2  out  1  one-hot phase strobes.
- busy  out  1  high in T0/T1/T2.
- done  out  1  one-cycle pulse at program completion.
- step  in  1  present only with MICRO_SEQ_STEP_EN.

## Operation
- States: IDLE, FETCH(T0), DECODE(T1), EXEC(T2), DONE.
- IDLE: pc=0; start=1 → FETCH, loop counter cnt ← LOOP_N.
- FETCH: prog_addr=pc; IR ← prog_data at end of cycle → DECODE.
- DECODE: opcode = IR[7:4] (held through EXEC); flag ← mult_bit at end of cycle → EXEC.
- EXEC: T2=1 for exactly one cycle. PC update at end of EXEC, in priority order:
  - END=1 → DONE (pc unchanged); END overrides LOOP.
  - LOOP=1 and cnt>1 → cnt−1, pc ← mark_pc.
  - LOOP=1 and cnt==1 → cnt ← 0, pc+1.
  - otherwise pc+1.
  - MARK=1 → mark_pc ← pc, applied before LOOP test; MARK+LOOP in one word gives a single-instruction loop.
  - Next state FETCH.
- DONE: done=1 for one cycle → IDLE, pc ← 0.
- pc+1 wraps modulo 2^PC_W. A program without END runs forever.
- LOOP with cnt==0 (second loop after exhaustion): treated as fall-through, pc+1.
- mark_pc resets to 0. LOOP before any MARK jumps to 0.
- start while busy: ignored.

## Timing
- Reset values: state IDLE, pc=0, IR=0, opcode=0, flag=0, cnt=0, mark_pc=0, T0/T1/T2/busy/done=0.
- reset mid-program: next cycle IDLE with all of the above; no T2 issued in the reset cycle.
- start high at cycle n (IDLE) → T0 at n+1, T1 at n+2, T2 at n+3.
- Each instruction takes 3 cycles. A program of k executed instructions gives done at 3k+1 cycles after start.
- opcode changes only at the FETCH→DECODE edge. It is stable for the whole of T1 and T2.
- flag is stable for the whole of T2.

## Configuration
- MICRO_SEQ_STEP_EN defined:
  - Adds the step input.
  - FETCH holds (T0 stays high, IR not loaded) until step=1.
  - One instruction executes per step pulse.
  - start still required from IDLE.
- Not defined:
  - The step port is absent.
  - FETCH always lasts one cycle.

## Structure
- Shared package micro_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, DONE).
  - instruction field bit positions (END_BIT=3, LOOP_BIT=2, MARK_BIT=1).
  - OPC_W=4.
  - The opcode constants 4'h0–4'hF shared with the control decoder.
- Sub-module micro_loop_ctr:
  - Holds cnt and mark_pc.
  - Inputs: load, mark, loop, pc.
  - Outputs: jump, target.
- Top-level micro_seq holds the FSM, pc and IR.

## Test plan
- Reset then start; program {0x0_0, 0x1_0, 0x2_8} → T2 pulses with opcodes 0,1,2, then done 10 cycles after start, pc returns 0.
- LOOP_N=8; program {0x0_0, 0x8_2 (MARK), 0x3_4 (LOOP), 0xF_8} → opcode 8 and 3 each issued 8 times, opcode F once, done at cycle 3·18+1=55.
- mult_bit toggled 1,0,1 across three DECODE phases → flag during the three T2 cycles reads 1,0,1.
- reset asserted during EXEC of instruction 2 → next cycle IDLE, opcode=0, T2=0, busy=0; new start runs from address 0.
- PC_W=2; program with no END, words 0x1_0 ×4 → prog_addr sequence 0,1,2,3,0; start pulses during busy are ignored.
- MICRO_SEQ_STEP_EN: step held low 5 cycles → T0 held, no T2; single step pulse → exactly one T2.
